// File: rtl/tm1637_rom_sequencer.sv
// ============================================================================
// Module   : tm1637_rom_sequencer
// Brief    : Walks a TM1637 command script held in ROM and bit-bangs it onto
//            the two-wire CLK/DIO bus. Optional macro TM1637_ACK_CHECK_EN
//            enables ACK sampling and the sticky ack_error flag.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef BLOCK_ROM_INIT_ADDR_WIDTH
`define BLOCK_ROM_INIT_ADDR_WIDTH 8
`endif
`ifndef BLOCK_ROM_INIT_DATA_WIDTH
`define BLOCK_ROM_INIT_DATA_WIDTH 16
`endif

module tm1637_rom_sequencer #(
    parameter int ADDR_WIDTH = `BLOCK_ROM_INIT_ADDR_WIDTH,
    parameter int DATA_WIDTH = `BLOCK_ROM_INIT_DATA_WIDTH,
    parameter int BASE_ADDR  = 0,
    parameter int CLK_DIV    = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_start,
    output logic [ADDR_WIDTH-1:0] o_rom_addr,
    input  logic [DATA_WIDTH-1:0] i_rom_data,
    output logic                  o_tm_clk,
    output logic                  o_dio_drive_low,
    input  logic                  i_dio_in,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_ack_error
);

    localparam int                    DIV_W      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0]      c_DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0]      c_DIV_ONE  = DIV_W'(1);
    localparam logic [ADDR_WIDTH-1:0] c_BASE     = ADDR_WIDTH'(BASE_ADDR);
    localparam logic [ADDR_WIDTH-1:0] c_ADDR_MAX = '1;
    localparam logic [ADDR_WIDTH-1:0] c_ADDR_ONE = ADDR_WIDTH'(1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_STARTC = 3'd2,
        S_BIT    = 3'd3,
        S_ACK    = 3'd4,
        S_STOPC  = 3'd5,
        S_NEXT   = 3'd6,
        S_FINISH = 3'd7
    } state_t;

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DIV_W-1:0]      r_div;
    logic [1:0]            r_q;
    logic [2:0]            r_bit;
    logic [7:0]            r_payload;
    logic                  r_stop;
    logic                  r_tm_clk;
    logic                  r_dio_low;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_ack_err;
    logic                  w_q_end;
    logic                  w_unused_data;

    assign w_q_end       = (r_div == c_DIV_LAST);
    assign w_unused_data = ^i_rom_data;

`ifndef TM1637_ACK_CHECK_EN
    logic w_unused_dio;
    assign w_unused_dio = i_dio_in;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_addr    <= c_BASE;
            r_div     <= '0;
            r_q       <= '0;
            r_bit     <= '0;
            r_payload <= '0;
            r_stop    <= 1'b0;
            r_tm_clk  <= 1'b1;
            r_dio_low <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_ack_err <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_div  <= w_q_end ? '0 : r_div + c_DIV_ONE;
            case (r_state)
                S_IDLE: begin
                    r_div     <= '0;
                    r_tm_clk  <= 1'b1;
                    r_dio_low <= 1'b0;
                    if (i_start) begin
                        r_addr    <= c_BASE;
                        r_ack_err <= 1'b0;
                        r_busy    <= 1'b1;
                        r_state   <= S_FETCH;
                    end
                end
                // Two cycles so a registered ROM has settled on the new address.
                S_FETCH: begin
                    if (r_div == '0) begin
                        r_div <= c_DIV_ONE;
                    end else begin
                        r_div     <= '0;
                        r_q       <= '0;
                        r_bit     <= '0;
                        r_stop    <= i_rom_data[8];
                        r_payload <= i_rom_data[7:0];
                        if (i_rom_data[10]) begin
                            r_state <= S_FINISH;
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                        end else if (i_rom_data[9]) begin
                            r_state   <= S_STARTC;
                            r_dio_low <= 1'b1;
                        end else begin
                            r_state  <= S_BIT;
                            r_tm_clk <= 1'b0;
                        end
                    end
                end
                S_STARTC: begin
                    if (w_q_end) begin
                        r_state  <= S_BIT;
                        r_tm_clk <= 1'b0;
                    end
                end
                S_BIT: begin
                    if (w_q_end) begin
                        case (r_q)
                            2'd0: begin
                                r_q       <= 2'd1;
                                r_dio_low <= ~r_payload[r_bit];
                            end
                            2'd1: begin
                                r_q      <= 2'd2;
                                r_tm_clk <= 1'b1;
                            end
                            2'd2: r_q <= 2'd3;
                            default: begin
                                r_q      <= 2'd0;
                                r_tm_clk <= 1'b0;
                                if (r_bit == 3'd7) begin
                                    r_bit   <= 3'd0;
                                    r_state <= S_ACK;
                                end else begin
                                    r_bit <= r_bit + 3'd1;
                                end
                            end
                        endcase
                    end
                end
                S_ACK: begin
`ifdef TM1637_ACK_CHECK_EN
                    if (r_q == 2'd2 && w_q_end && i_dio_in) begin
                        r_ack_err <= 1'b1;
                    end
`endif
                    if (w_q_end) begin
                        case (r_q)
                            2'd0: begin
                                r_q       <= 2'd1;
                                r_dio_low <= 1'b0;
                            end
                            2'd1: begin
                                r_q      <= 2'd2;
                                r_tm_clk <= 1'b1;
                            end
                            2'd2: r_q <= 2'd3;
                            default: begin
                                r_q <= 2'd0;
                                if (r_stop) begin
                                    r_state   <= S_STOPC;
                                    r_tm_clk  <= 1'b0;
                                    r_dio_low <= 1'b1;
                                end else begin
                                    r_state <= S_NEXT;
                                end
                            end
                        endcase
                    end
                end
                S_STOPC: begin
                    if (w_q_end) begin
                        case (r_q)
                            2'd0: begin
                                r_q      <= 2'd1;
                                r_tm_clk <= 1'b1;
                            end
                            2'd1: begin
                                r_q       <= 2'd2;
                                r_dio_low <= 1'b0;
                            end
                            default: begin
                                r_q     <= 2'd0;
                                r_state <= S_NEXT;
                            end
                        endcase
                    end
                end
                // The last ROM location terminates the script instead of wrapping.
                S_NEXT: begin
                    r_div <= '0;
                    if (r_addr == c_ADDR_MAX) begin
                        r_state <= S_FINISH;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                    end else begin
                        r_addr  <= r_addr + c_ADDR_ONE;
                        r_state <= S_FETCH;
                    end
                end
                S_FINISH: begin
                    r_div     <= '0;
                    r_tm_clk  <= 1'b1;
                    r_dio_low <= 1'b0;
                    r_state   <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_rom_addr      = r_addr;
    assign o_tm_clk        = r_tm_clk;
    assign o_dio_drive_low = r_dio_low;
    assign o_busy          = r_busy;
    assign o_done          = r_done;
    assign o_ack_error     = r_ack_err;

endmodule

`default_nettype wire

// File: tb/tb_tm1637_rom_sequencer.sv
// ============================================================================
// Module   : tb_tm1637_rom_sequencer
// Brief    : Self-checking bench; decodes the TM1637 bus into start/stop/byte
//            events and compares them with a script-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tm1637_rom_sequencer;
    localparam int CD       = 2;
    localparam int EV_START = 256;
    localparam int EV_STOP  = 512;
    localparam int EV_ACK   = 1024;
    localparam int BUDGET   = 4000;

    typedef struct packed {
        logic [5:0][15:0] e;
        logic [7:0]       nack;
        logic [3:0]       n_start;
        logic [3:0]       n_stop;
        logic [3:0]       fin;
    } vec_t;

    logic        clk    = 1'b0;
    logic        reset  = 1'b1;
    logic        start  = 1'b0;
    logic        sel    = 1'b0;
    logic        dio_in = 1'b0;
    logic [15:0] script [16];
    logic [15:0] rd1 = '0;
    logic [15:0] rd2 = '0;
    logic [3:0]  addr1;
    logic [1:0]  addr2;
    logic        tmc1, dlo1, busy1, done1, ack1;
    logic        tmc2, dlo2, busy2, done2, ack2;
    logic        w_tmc, w_dlo, w_busy, w_done, w_ack;
    logic [3:0]  w_addr;

    always #5 clk = ~clk;

    // Registered-read ROMs sharing one script array.
    always @(posedge clk) begin
        rd1 <= script[addr1];
        rd2 <= script[{2'b00, addr2}];
    end

    tm1637_rom_sequencer #(.ADDR_WIDTH(4), .DATA_WIDTH(16), .BASE_ADDR(0), .CLK_DIV(CD)) dut (
        .clk(clk), .reset(reset), .i_start(start & ~sel), .o_rom_addr(addr1), .i_rom_data(rd1),
        .o_tm_clk(tmc1), .o_dio_drive_low(dlo1), .i_dio_in(dio_in), .o_busy(busy1),
        .o_done(done1), .o_ack_error(ack1));

    tm1637_rom_sequencer #(.ADDR_WIDTH(2), .DATA_WIDTH(16), .BASE_ADDR(0), .CLK_DIV(CD)) dut2 (
        .clk(clk), .reset(reset), .i_start(start & sel), .o_rom_addr(addr2), .i_rom_data(rd2),
        .o_tm_clk(tmc2), .o_dio_drive_low(dlo2), .i_dio_in(dio_in), .o_busy(busy2),
        .o_done(done2), .o_ack_error(ack2));

    assign w_tmc  = sel ? tmc2 : tmc1;
    assign w_dlo  = sel ? dlo2 : dlo1;
    assign w_busy = sel ? busy2 : busy1;
    assign w_done = sel ? done2 : done1;
    assign w_ack  = sel ? ack2 : ack1;
    assign w_addr = sel ? {2'b00, addr2} : addr1;

    int          total = 0;
    int          bad   = 0;
    int          evq[$];
    int          expq[$];
    int          exp_lat = 0;
    int          exp_fin = 0;
    logic        exp_ack = 1'b0;
    logic [7:0]  nack_mask = '0;
    int          clr_seq = 0;

    // Bus monitor state (written only by the monitor process).
    int          clr_seen = 0;
    int          bitcnt = 0;
    int          nbytes = 0;
    int          rise0 = 0;
    int          cyc_now = 0;
    int          span_bad = 0;
    int          span_seen = 0;
    logic        prev_clk = 1'b1;
    logic        prev_dio = 1'b1;
    logic [7:0]  shreg = '0;
    logic        wrap = 1'b0;
    logic [3:0]  prev_addr = '0;

    always @(negedge clk) begin
        logic cur_clk, cur_dio;
        cyc_now++;
        if (clr_seen != clr_seq) begin
            clr_seen  = clr_seq;
            evq.delete();
            nbytes    = 0;
            span_bad  = 0;
            span_seen = 0;
            wrap      = 1'b0;
        end
        if (reset) begin
            prev_clk = 1'b1;
            prev_dio = 1'b1;
            bitcnt   = 0;
            dio_in   = 1'b0;
        end else begin
            cur_clk = w_tmc;
            cur_dio = ~w_dlo;
            if (cur_clk && prev_clk && cur_dio != prev_dio) begin
                evq.push_back(cur_dio ? EV_STOP : EV_START);
                bitcnt = 0;
            end else if (cur_clk && !prev_clk) begin
                if (bitcnt < 8) begin
                    if (bitcnt == 0) rise0 = cyc_now;
                    shreg[bitcnt] = cur_dio;
                    bitcnt++;
                    if (bitcnt == 8) begin
                        evq.push_back(int'(shreg));
                        nbytes++;
                    end
                end else begin
                    evq.push_back(EV_ACK);
                    span_seen++;
                    if (cyc_now - rise0 != 32 * CD) span_bad++;
                    bitcnt = 0;
                end
            end
            prev_clk = cur_clk;
            prev_dio = cur_dio;
            if (w_busy && prev_addr == (sel ? 4'd3 : 4'd15) && w_addr == 4'd0) wrap = 1'b1;
            prev_addr = w_addr;
            dio_in = (nbytes > 0) ? nack_mask[(nbytes - 1) & 7] : 1'b0;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Script-level model: walk entries, emit bus events, sum phase durations.
    function automatic void build_exp(input int maxa);
        int          a  = 0;
        int          nb = 0;
        logic [15:0] e;
        expq.delete();
        exp_lat = 0;
        exp_ack = 1'b0;
        while (1) begin
            e = script[a];
            if (e[10]) begin
                exp_lat += 2;
                break;
            end
            exp_lat += 2 + 36 * CD + 1;
            if (e[9]) begin
                expq.push_back(EV_START);
                exp_lat += CD;
            end
            expq.push_back(int'(e[7:0]));
            expq.push_back(EV_ACK);
            if (e[8]) begin
                expq.push_back(EV_STOP);
                exp_lat += 3 * CD;
            end
            if (nack_mask[nb & 7]) exp_ack = 1'b1;
            nb++;
            if (a == maxa) break;
            a++;
        end
        exp_fin = a;
`ifndef TM1637_ACK_CHECK_EN
        exp_ack = 1'b0;
`endif
    endfunction

    function automatic int count_ev(input int code);
        int n = 0;
        foreach (evq[i]) if (evq[i] == code) n++;
        return n;
    endfunction

    function automatic int first_diff();
        if (evq.size() != expq.size()) return -2;
        foreach (evq[i]) if (evq[i] != expq[i]) return i;
        return -1;
    endfunction

    task automatic run(input string tag, input int extra_at, input bit at_done, input bit do_reset);
        int lat, ndone, nacks;
        bit busy_gap, busy_after, did_reset;
        build_exp(sel ? 3 : 15);
        nacks = 0;
        foreach (expq[i]) if (expq[i] == EV_ACK) nacks++;
        clr_seq++;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check({tag, ":busy_after_start"}, w_busy, 1);
        check({tag, ":ack_cleared"}, w_ack, 0);
        lat = -1; ndone = 0; busy_gap = 0; did_reset = 0;
        for (int c = 1; c <= BUDGET; c++) begin
            start = (c == extra_at);
            @(posedge clk); #1;
            if (do_reset && nbytes == 2 && bitcnt == 3 && !w_tmc) begin
                start = 1'b0;
                reset = 1'b1;
                #1;
                check({tag, ":rst_tm_clk"}, w_tmc, 1);
                check({tag, ":rst_dio"}, w_dlo, 0);
                check({tag, ":rst_busy"}, w_busy, 0);
                check({tag, ":rst_addr"}, w_addr, 0);
                @(posedge clk); #1;
                reset = 1'b0;
                did_reset = 1;
                break;
            end
            if (w_done) begin
                lat = c;
                ndone++;
                break;
            end
            if (!w_busy) busy_gap = 1;
        end
        start = 1'b0;
        if (do_reset) begin
            check({tag, ":reset_hit"}, did_reset, 1);
            return;
        end
        if (at_done) start = 1'b1;
        busy_after = 0;
        repeat (20) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (w_done) ndone++;
            if (w_busy) busy_after = 1;
        end
        check({tag, ":latency"}, lat, exp_lat);
        check({tag, ":done_count"}, ndone, 1);
        check({tag, ":busy_held"}, busy_gap, 0);
        check({tag, ":idle_after"}, busy_after, 0);
        check({tag, ":stream_diff"}, first_diff(), -1);
        check({tag, ":span_bad"}, span_bad, 0);
        check({tag, ":span_seen"}, span_seen, nacks);
        check({tag, ":final_addr"}, w_addr, exp_fin);
        check({tag, ":ack_error"}, w_ack, exp_ack);
        check({tag, ":no_wrap"}, wrap, 0);
    endtask

    vec_t tbl [4];

    initial begin
        for (int i = 0; i < 4; i++) tbl[i] = '0;
        tbl[0].e[0] = 16'h0340; tbl[0].e[1] = 16'h0400;
        tbl[0].n_start = 4'd1;  tbl[0].n_stop = 4'd1; tbl[0].fin = 4'd1;
        tbl[1].e[0] = 16'h0340; tbl[1].e[1] = 16'h02C0; tbl[1].e[2] = 16'h003F;
        tbl[1].e[3] = 16'h0106; tbl[1].e[4] = 16'h038F; tbl[1].e[5] = 16'h0400;
        tbl[1].n_start = 4'd3;  tbl[1].n_stop = 4'd3; tbl[1].fin = 4'd5;
        tbl[2] = tbl[1];
        tbl[2].e[0] = 16'hA340; tbl[2].e[5] = 16'hFC00; tbl[2].nack = 8'b0000_0010;
        tbl[3].e[0] = 16'h07FF;
        tbl[3].n_start = 4'd0;  tbl[3].n_stop = 4'd0; tbl[3].fin = 4'd0;

        for (int i = 0; i < 16; i++) script[i] = 16'h0400;

        repeat (3) @(posedge clk);
        #1;
        check("reset:tm_clk", tmc1, 1);
        check("reset:dio", dlo1, 0);
        check("reset:busy", busy1, 0);
        check("reset:done", done1, 0);
        check("reset:ack", ack1, 0);
        check("reset:addr", addr1, 0);
        check("reset:addr2", addr2, 0);
        @(negedge clk);
        reset = 1'b0;

        for (int v = 0; v < 4; v++) begin
            for (int i = 0; i < 6; i++) script[i] = tbl[v].e[i];
            for (int i = 6; i < 16; i++) script[i] = 16'h0000;
            nack_mask = tbl[v].nack;
            run($sformatf("vec%0d", v), 0, 1'b0, 1'b0);
            check($sformatf("vec%0d:n_start", v), count_ev(EV_START), tbl[v].n_start);
            check($sformatf("vec%0d:n_stop", v), count_ev(EV_STOP), tbl[v].n_stop);
            check($sformatf("vec%0d:fin", v), w_addr, tbl[v].fin);
        end

        for (int i = 0; i < 6; i++) script[i] = tbl[1].e[i];
        nack_mask = '0;
        run("start_busy", 150, 1'b0, 1'b0);
        run("start_at_done", 0, 1'b1, 1'b0);
        run("reset_mid", 0, 1'b0, 1'b1);
        run("replay", 0, 1'b0, 1'b0);

        sel = 1'b1;
        for (int i = 0; i < 4; i++) script[i] = 16'h0355;
        run("no_end", 0, 1'b0, 1'b0);
        check("no_end:n_start", count_ev(EV_START), 4);
        check("no_end:n_stop", count_ev(EV_STOP), 4);
        sel = 1'b0;

        for (int r = 0; r < 10; r++) begin
            int          len;
            logic [31:0] rv;
            len = $urandom_range(1, 6);
            for (int i = 0; i < 16; i++) script[i] = 16'h0000;
            for (int i = 0; i < len; i++) begin
                rv = $urandom;
                script[i] = rv[15:0] & 16'hFBFF;
            end
            rv = $urandom;
            script[len] = rv[15:0] | 16'h0400;
            rv = $urandom;
            nack_mask = rv[7:0];
            run($sformatf("rand%0d", r), int'($urandom_range(0, 300)), rv[8], 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
